multi_channel_clk_gen: RTL and testbench

Parametrised, multi-channel successor to the single-output divider. It replaces the divide-based `clkbase/clkdiv` scheme with direct cycle-count programming of period and high time, giving arbitrary duty cycle per channel. It adds one-shot mode, phase-aligned restart and glitch-free reconfiguration at period boundaries. It sits beside the board drivers (DS1302, display scan, buzzer, key sampling) and supplies their enables and slow clocks from the 50 MHz system clock.

---
 rtl/multi_channel_clk_gen.sv | 110 +++++++++++
 tb/tb_multi_channel_clk_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_clk_gen.sv
// Multi-channel programmable clock/enable generator: per-channel period and high
// time in clk cycles, continuous or one-shot, with boundary-aligned reconfiguration.
module multi_channel_clk_gen #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic              cfg_oneshot,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH-1:0]   start,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   busy
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] sh_p, sh_h, act_p, act_h, cnt;
      logic             sh_os, act_os, pending, running, en_d;
      logic [CNT_W-1:0] sh_p_next, sh_h_next, cand_p, cand_h;
      logic [CNT_W-1:0] act_p_next, act_h_next, cnt_next;
      logic             sh_os_next, cand_os, act_os_next, pend_eff;
      logic             pending_next, running_next;
      logic             wr, wrap, start_ev, apply;
      logic             clk_out_reg, tick_reg, busy_reg;

      always_comb begin
        // A write in this cycle bypasses the shadow so it is visible to apply/start.
        wr         = cfg_we && (cfg_ch == CH_W'(gi));
        sh_p_next  = wr ? cfg_period  : sh_p;
        sh_h_next  = wr ? cfg_high    : sh_h;
        sh_os_next = wr ? cfg_oneshot : sh_os;
        pend_eff   = wr || pending;

        cand_p  = pend_eff ? sh_p_next  : act_p;
        cand_h  = pend_eff ? sh_h_next  : act_h;
        cand_os = pend_eff ? sh_os_next : act_os;

        wrap     = running && (cnt == act_p - CNT_W'(1));
        start_ev = ch_en[gi] && (start[gi] || !en_d) && (cand_p != '0);
        apply    = !running || wrap || start_ev || !ch_en[gi];

        act_p_next   = apply ? cand_p  : act_p;
        act_h_next   = apply ? cand_h  : act_h;
        act_os_next  = apply ? cand_os : act_os;
        pending_next = apply ? 1'b0    : pend_eff;

        cnt_next     = cnt;
        running_next = running;
        if (!ch_en[gi]) begin
          cnt_next     = '0;
          running_next = 1'b0;
        end else if (start_ev) begin
          cnt_next     = '0;
          running_next = 1'b1;
        end else if (wrap) begin
          // One-shot ends on its own period's mode; a newly applied P = 0 stops too.
          cnt_next     = '0;
          running_next = !act_os && (cand_p != '0);
        end else if (running) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_p        <= '0;
          sh_h        <= '0;
          sh_os       <= 1'b0;
          pending     <= 1'b0;
          act_p       <= '0;
          act_h       <= '0;
          act_os      <= 1'b0;
          cnt         <= '0;
          running     <= 1'b0;
          en_d        <= 1'b0;
          clk_out_reg <= 1'b0;
          tick_reg    <= 1'b0;
          busy_reg    <= 1'b0;
        end else begin
          sh_p        <= sh_p_next;
          sh_h        <= sh_h_next;
          sh_os       <= sh_os_next;
          pending     <= pending_next;
          act_p       <= act_p_next;
          act_h       <= act_h_next;
          act_os      <= act_os_next;
          cnt         <= cnt_next;
          running     <= running_next;
          en_d        <= ch_en[gi];
          clk_out_reg <= running_next && (cnt_next < act_h_next);
          tick_reg    <= running_next && (cnt_next == '0);
          busy_reg    <= running_next;
        end
      end

      assign clk_out[gi] = clk_out_reg;
      assign tick[gi]    = tick_reg;
      assign busy[gi]    = busy_reg;
    end
  endgenerate

endmodule

// File: tb/tb_multi_channel_clk_gen.sv
// Self-checking bench for multi_channel_clk_gen: expected waveforms come from
// plain period arithmetic (position = cycles since start mod P).
module tb_multi_channel_clk_gen;
  localparam int N_CH  = 5;
  localparam int CNT_W = 16;
  localparam int CH_W  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period, cfg_high;
  logic             cfg_oneshot;
  logic [N_CH-1:0]  ch_en, start, clk_out, tick, busy;

  int checks   = 0;
  int failures = 0;

  multi_channel_clk_gen #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_oneshot(cfg_oneshot),
    .ch_en(ch_en), .start(start), .clk_out(clk_out), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stimulus only: one-cycle configuration write, issued and returned at a negedge.
  task automatic cfg_write(input int ch, input int p, input int h, input bit os);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch);
    cfg_period = CNT_W'(p); cfg_high = CNT_W'(h); cfg_oneshot = os;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (clk_out !== '0) begin failures++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
    checks++; if (tick !== '0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (busy !== '0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== '0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_continuous();
    int p, h;
    for (int t = 0; t < 3; t++) begin
      p = (t == 0) ? 5 : int'($urandom_range(2, 12));
      h = (t == 0) ? 2 : int'($urandom_range(0, p + 1));
      ch_en[0] = 1'b0; @(negedge clk);
      cfg_write(0, p, h, 1'b0);
      ch_en[0] = 1'b1;
      for (int k = 0; k < 3 * p; k++) begin
        @(negedge clk);
        checks++;
        if ({clk_out[0], tick[0], busy[0]} !== {((k % p) < h), ((k % p) == 0), 1'b1}) begin
          failures++;
          $display("FAIL cont P=%0d H=%0d k=%0d got clk/tick/busy=%b%b%b exp=%b%b1",
                   p, h, k, clk_out[0], tick[0], busy[0], ((k % p) < h), ((k % p) == 0));
        end
      end
      ch_en[0] = 1'b0; @(negedge clk);
      $display("test_continuous P=%0d H=%0d done", p, h);
    end
  endtask

  task automatic test_reconfig();
    int off, p1, h1, pos, hh, pp;
    for (int t = 0; t < 3; t++) begin
      off = (t == 0) ? 2 : int'($urandom_range(0, 7));
      p1  = (t == 0) ? 4 : int'($urandom_range(2, 9));
      h1  = (t == 0) ? 1 : int'($urandom_range(0, p1));
      ch_en[1] = 1'b0; @(negedge clk);
      cfg_write(1, 8, 4, 1'b0);
      ch_en[1] = 1'b1;
      for (int k = 0; k < 8 + 2 * p1; k++) begin
        @(negedge clk);
        if (k < 8) begin pos = k; pp = 8; hh = 4; end
        else begin pos = (k - 8) % p1; pp = p1; hh = h1; end
        checks++;
        if ({clk_out[1], tick[1], busy[1]} !== {(pos < hh), (pos == 0), 1'b1}) begin
          failures++;
          $display("FAIL reconfig off=%0d P=%0d k=%0d got clk/tick/busy=%b%b%b exp=%b%b1",
                   off, pp, k, clk_out[1], tick[1], busy[1], (pos < hh), (pos == 0));
        end
        if (k == off) begin
          cfg_we = 1'b1; cfg_ch = 3'd1; cfg_period = CNT_W'(p1);
          cfg_high = CNT_W'(h1); cfg_oneshot = 1'b0;
        end else begin
          cfg_we = 1'b0;
        end
      end
      cfg_we = 1'b0; ch_en[1] = 1'b0; @(negedge clk);
      $display("test_reconfig off=%0d newP=%0d newH=%0d done", off, p1, h1);
    end
  endtask

  task automatic test_oneshot();
    int off, p, h, pos;
    bit eb;
    // Enable while applied P is still 0: no start may occur.
    ch_en[2] = 1'b1; @(negedge clk);
    checks++; if (busy[2] !== 1'b0) begin failures++; $display("FAIL oneshot_p0_busy got=%b exp=0", busy[2]); end
    cfg_write(2, 6, 3, 1'b1);
    checks++; if (busy[2] !== 1'b0) begin failures++; $display("FAIL oneshot_cfg_busy got=%b exp=0", busy[2]); end
    for (int t = 0; t < 2; t++) begin
      p = (t == 0) ? 6 : int'($urandom_range(1, 10));
      h = (t == 0) ? 3 : int'($urandom_range(0, p + 1));
      if (t == 1) cfg_write(2, p, h, 1'b1);
      start[2] = 1'b1;
      for (int k = 0; k < p + 4; k++) begin
        @(negedge clk);
        start[2] = 1'b0;
        eb = (k < p);
        checks++;
        if ({clk_out[2], tick[2], busy[2]} !== {eb && (k < h), eb && (k == 0), eb}) begin
          failures++;
          $display("FAIL oneshot P=%0d H=%0d k=%0d got clk/tick/busy=%b%b%b exp=%b%b%b",
                   p, h, k, clk_out[2], tick[2], busy[2], eb && (k < h), eb && (k == 0), eb);
        end
      end
      $display("test_oneshot P=%0d H=%0d done", p, h);
    end
    // Restart mid-period: busy lasts off + P cycles in total.
    cfg_write(2, 6, 3, 1'b1);
    off = int'($urandom_range(1, 5));
    start[2] = 1'b1;
    for (int k = 0; k < off + 9; k++) begin
      @(negedge clk);
      start[2] = (k == off - 1);
      pos = (k < off) ? k : k - off;
      eb  = (k < off + 6);
      checks++;
      if ({clk_out[2], tick[2], busy[2]} !== {eb && (pos < 3), eb && (pos == 0), eb}) begin
        failures++;
        $display("FAIL oneshot_restart off=%0d k=%0d got clk/tick/busy=%b%b%b exp=%b%b%b",
                 off, k, clk_out[2], tick[2], busy[2], eb && (pos < 3), eb && (pos == 0), eb);
      end
    end
    start[2] = 1'b0; ch_en[2] = 1'b0; @(negedge clk);
    $display("test_oneshot restart off=%0d done", off);
  endtask

  task automatic test_boundaries();
    int p, h, pos;
    bit r;
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: begin p = 0; h = 3; end
        1: begin p = 1; h = 1; end
        2: begin p = int'($urandom_range(2, 9)); h = 0; end
        default: begin p = 4; h = 9; end
      endcase
      ch_en[4] = 1'b0; @(negedge clk);
      cfg_write(4, p, h, 1'b0);
      ch_en[4] = 1'b1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        r   = (p != 0);
        pos = (p != 0) ? (k % p) : 0;
        checks++;
        if ({clk_out[4], tick[4], busy[4]} !== {r && (pos < h), r && (pos == 0), r}) begin
          failures++;
          $display("FAIL boundary P=%0d H=%0d k=%0d got clk/tick/busy=%b%b%b exp=%b%b%b",
                   p, h, k, clk_out[4], tick[4], busy[4], r && (pos < h), r && (pos == 0), r);
        end
      end
      ch_en[4] = 1'b0; @(negedge clk);
      $display("test_boundaries P=%0d H=%0d done", p, h);
    end
  endtask

  task automatic test_phase_align();
    int d;
    ch_en[0] = 1'b0; ch_en[3] = 1'b0; @(negedge clk);
    cfg_write(0, 10, 5, 1'b0);
    cfg_write(3, 5, 2, 1'b0);
    ch_en[0] = 1'b1;
    d = int'($urandom_range(1, 4));
    repeat (d) @(negedge clk);
    ch_en[3] = 1'b1;
    repeat ($urandom_range(3, 12)) @(negedge clk);
    start[0] = 1'b1; start[3] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      start[0] = 1'b0; start[3] = 1'b0;
      checks++;
      if ({tick[0], tick[3], clk_out[0], clk_out[3]} !==
          {((k % 10) == 0), ((k % 5) == 0), ((k % 10) < 5), ((k % 5) < 2)}) begin
        failures++;
        $display("FAIL phase_align k=%0d got tick0/tick3/clk0/clk3=%b%b%b%b exp=%b%b%b%b",
                 k, tick[0], tick[3], clk_out[0], clk_out[3],
                 ((k % 10) == 0), ((k % 5) == 0), ((k % 10) < 5), ((k % 5) < 2));
      end
    end
    ch_en[0] = 1'b0; ch_en[3] = 1'b0; @(negedge clk);
    $display("test_phase_align skew=%0d done", d);
  endtask

  task automatic test_reset_disable();
    int m;
    ch_en[1] = 1'b0; @(negedge clk);
    cfg_write(1, 7, 3, 1'b0);
    ch_en[1] = 1'b1;
    m = int'($urandom_range(1, 5));
    repeat (m + 1) @(negedge clk);
    checks++; if (busy[1] !== 1'b1) begin failures++; $display("FAIL disable_pre_busy got=%b exp=1", busy[1]); end
    ch_en[1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({clk_out[1], tick[1], busy[1]} !== 3'b000) begin
      failures++;
      $display("FAIL disable m=%0d got clk/tick/busy=%b%b%b exp=000", m, clk_out[1], tick[1], busy[1]);
    end
    $display("test_disable m=%0d done", m);

    ch_en[0] = 1'b1; ch_en[1] = 1'b1;
    repeat ($urandom_range(2, 6)) @(negedge clk);
    checks++; if (busy[1:0] !== 2'b11) begin failures++; $display("FAIL rst_pre_busy got=%b exp=11", busy[1:0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_out, tick, busy} !== '0) begin
      failures++;
      $display("FAIL async_reset got clk_out=%b tick=%b busy=%b exp=0", clk_out, tick, busy);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({tick, busy} !== '0) begin
        failures++;
        $display("FAIL post_reset_idle k=%0d got tick=%b busy=%b exp=0", k, tick, busy);
      end
    end
    $display("test_reset_mid_period done");

    ch_en = '0; @(negedge clk);
    cfg_write(N_CH, 3, 1, 1'b0);
    ch_en = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({tick, busy, clk_out} !== '0) begin
        failures++;
        $display("FAIL bad_ch_write k=%0d got tick=%b busy=%b clk_out=%b exp=0", k, tick, busy, clk_out);
      end
    end
    ch_en = '0; @(negedge clk);
    $display("test_bad_channel_write done");
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
    cfg_oneshot = 1'b0; ch_en = '0; start = '0;
    @(negedge clk);
    test_reset();
    test_continuous();
    test_reconfig();
    test_oneshot();
    test_boundaries();
    test_phase_align();
    test_reset_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
